piso_d_ff: RTL and testbench

//  Parallel-in serial-out shift register with a load handshake. It is the

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_d_ff_if.sv | 23 ++
 rtl/piso_bit_cnt.sv | 30 +++
 rtl/piso_d_ff.sv | 107 ++++++++++
 tb/tb_piso_d_ff.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_d_ff parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH   = 4;
  localparam bit MSB_FIRST_ORDER = 1'b1;
  localparam bit LSB_FIRST_ORDER = 1'b0;

endpackage

// File: rtl/piso_d_ff_if.sv
// Load handshake plus serial output bundle of piso_d_ff.
interface piso_d_ff_if import piso_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] d_pin;
  logic             load_valid;
  logic             load_ready;
  logic             q_sout;
  logic             sout_valid;
  logic             sout_last;

  modport master (
    output d_pin, load_valid,
    input  load_ready, q_sout, sout_valid, sout_last
  );

  modport slave (
    input  d_pin, load_valid,
    output load_ready, q_sout, sout_valid, sout_last
  );

endinterface

// File: rtl/piso_bit_cnt.sv
// Loadable down-counter that saturates at zero and flags the zero state.
module piso_bit_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic          zero
);

  logic [CW-1:0] cnt_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/piso_d_ff.sv
// Parallel-in serial-out shift register with valid/ready load and gapless streaming.
module piso_d_ff import piso_pkg::*; #(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = MSB_FIRST_ORDER
) (
  input logic        clk,
  input logic        rst,
  piso_d_ff_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] shreg_r;
  logic             zero_s;
  logic             accept_s;
  logic             dec_s;
  logic             out_bit_s;
  logic             load_ready_s;
  logic             q_sout_s;
  logic             sout_valid_s;
  logic             sout_last_s;

  // load_ready never looks at load_valid, so accept has no loop through the source.
  assign accept_s  = bus.load_valid & load_ready_s;
  assign dec_s     = (state_r == SHIFT) & ~zero_s;
  assign out_bit_s = (MSB_FIRST == MSB_FIRST_ORDER) ? shreg_r[WIDTH-1] : shreg_r[0];

  piso_bit_cnt #(.CW(CW)) u_bit_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .dec      (dec_s),
    .load_val (LAST_IDX),
    .zero     (zero_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: a load on the last bit keeps streaming with no gap.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = SHIFT;
        else          state_nxt_s = IDLE;
      end
      SHIFT: begin
        if (!zero_s)       state_nxt_s = SHIFT;
        else if (accept_s) state_nxt_s = SHIFT;
        else               state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    load_ready_s = 1'b1;
    q_sout_s     = 1'b0;
    sout_valid_s = 1'b0;
    sout_last_s  = 1'b0;
    case (state_r)
      IDLE: begin
        load_ready_s = 1'b1;
      end
      SHIFT: begin
        load_ready_s = zero_s;
        q_sout_s     = out_bit_s;
        sout_valid_s = 1'b1;
        sout_last_s  = zero_s;
      end
      default: begin
        load_ready_s = 1'b1;
      end
    endcase
  end

  // Shift register: d_pin is sampled only on accept, so X elsewhere never enters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_r <= '0;
    end else if (accept_s) begin
      shreg_r <= bus.d_pin;
    end else if (state_r == SHIFT) begin
      if (MSB_FIRST == MSB_FIRST_ORDER) shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
      else                              shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
    end else begin
      shreg_r <= shreg_r;
    end
  end

  assign bus.load_ready = load_ready_s;
  assign bus.q_sout     = q_sout_s;
  assign bus.sout_valid = sout_valid_s;
  assign bus.sout_last  = sout_last_s;

endmodule

// File: tb/tb_piso_d_ff.sv
// Directed bench for piso_d_ff: MSB-first and LSB-first instances on one clock.
module tb_piso_d_ff;
  import piso_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  piso_d_ff_if #(.WIDTH(4)) bus_m ();
  piso_d_ff_if #(.WIDTH(4)) bus_l ();

  piso_d_ff #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
  piso_d_ff #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed vector order: {sout_valid, sout_last, load_ready, q_sout}
  task automatic test_reset();
    rst = 1'b0;
    bus_m.load_valid = 1'b1; bus_m.d_pin = 4'b1111;
    bus_l.load_valid = 1'b1; bus_l.d_pin = 4'b1111;
    tick(); tick();
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_msb got %b want 0010",
               {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
    end
    n_cmp++;
    if ({bus_l.sout_valid, bus_l.sout_last, bus_l.load_ready, bus_l.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_lsb got %b want 0010",
               {bus_l.sout_valid, bus_l.sout_last, bus_l.load_ready, bus_l.q_sout});
    end
    bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
    bus_l.load_valid = 1'b0; bus_l.d_pin = 4'bxxxx;
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL reset_release got %b want 0010",
               {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
    end
  endtask

  task automatic test_single();
    logic [3:0] exp_q;
    exp_q = 4'b1011;
    bus_m.d_pin = 4'b1011; bus_m.load_valid = 1'b1;
    tick();
    bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !==
          {1'b1, (i == 3), (i == 3), exp_q[3-i]}) begin
        n_err++;
        $display("FAIL single bit%0d got %b want %b", i,
                 {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout},
                 {1'b1, (i == 3), (i == 3), exp_q[3-i]});
      end
      tick();
    end
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL single_idle got %b want 0010",
               {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q;
    exp_q = 8'b1011_0110;
    bus_m.d_pin = 4'b1011; bus_m.load_valid = 1'b1;
    tick();
    bus_m.d_pin = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !==
          {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), exp_q[7-i]}) begin
        n_err++;
        $display("FAIL b2b bit%0d got %b want %b", i,
                 {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout},
                 {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), exp_q[7-i]});
      end
      tick();
      if (i == 3) begin
        bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
      end
    end
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL b2b_idle got %b want 0010",
               {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
    end
  endtask

  task automatic test_load_during_shift();
    logic [7:0] exp_q;
    exp_q = 8'b1100_0011;
    bus_m.d_pin = 4'b1100; bus_m.load_valid = 1'b1;
    tick();
    bus_m.d_pin = 4'b0011;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !==
          {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), exp_q[7-i]}) begin
        n_err++;
        $display("FAIL lds bit%0d got %b want %b", i,
                 {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout},
                 {1'b1, (i == 3 || i == 7), (i == 3 || i == 7), exp_q[7-i]});
      end
      tick();
      if (i == 3) begin
        bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
      end
    end
    n_cmp++;
    if (bus_m.sout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lds_idle sout_valid got %b want 0", bus_m.sout_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus_m.d_pin = 4'b1001; bus_m.load_valid = 1'b1;
    tick();
    bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.q_sout} !== 2'b11) begin
      n_err++;
      $display("FAIL mid_bit0 got %b want 11", {bus_m.sout_valid, bus_m.q_sout});
    end
    tick();
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.q_sout} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_bit1 got %b want 10", {bus_m.sout_valid, bus_m.q_sout});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
      n_err++;
      $display("FAIL mid_async got %b want 0010",
               {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
    end
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout} !== 4'b0010) begin
        n_err++;
        $display("FAIL mid_noresume cyc%0d got %b want 0010", i,
                 {bus_m.sout_valid, bus_m.sout_last, bus_m.load_ready, bus_m.q_sout});
      end
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] exp_q;
    exp_q = 4'b1000;
    bus_l.d_pin = 4'b0001; bus_l.load_valid = 1'b1;
    tick();
    bus_l.load_valid = 1'b0; bus_l.d_pin = 4'bxxxx;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({bus_l.sout_valid, bus_l.sout_last, bus_l.load_ready, bus_l.q_sout} !==
          {1'b1, (i == 3), (i == 3), exp_q[3-i]}) begin
        n_err++;
        $display("FAIL lsb bit%0d got %b want %b", i,
                 {bus_l.sout_valid, bus_l.sout_last, bus_l.load_ready, bus_l.q_sout},
                 {1'b1, (i == 3), (i == 3), exp_q[3-i]});
      end
      tick();
    end
    n_cmp++;
    if (bus_l.sout_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_idle sout_valid got %b want 0", bus_l.sout_valid);
    end
  endtask

  // Bench-side serial-in parallel-out receiver clocked on sout_valid cycles.
  task automatic test_loopback();
    logic [3:0] word;
    logic [3:0] rx;
    logic       got_last;
    for (int w = 0; w < 8; w++) begin
      word = 4'($urandom_range(0, 15));
      bus_m.d_pin = word; bus_m.load_valid = 1'b1;
      tick();
      bus_m.load_valid = 1'b0; bus_m.d_pin = 4'bxxxx;
      rx = 4'b0000;
      got_last = 1'b0;
      for (int c = 0; c < 10 && !got_last; c++) begin
        if (bus_m.sout_valid === 1'b1) begin
          rx = {rx[2:0], bus_m.q_sout};
          if (bus_m.sout_last === 1'b1) got_last = 1'b1;
        end
        tick();
      end
      n_cmp++;
      if (!got_last || rx !== word) begin
        n_err++;
        $display("FAIL loopback w%0d got %b last=%b want %b", w, rx, got_last, word);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus_m.load_valid = 1'b0; bus_m.d_pin = 4'b0000;
    bus_l.load_valid = 1'b0; bus_l.d_pin = 4'b0000;
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_load_during_shift();
    test_reset_mid();
    test_lsb_first();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
